// File: rtl/mips_multicycle.sv
// Multicycle MIPS subset core with one shared instruction/data memory port.
// Latency (zero-wait memory): R-type/addi 4 cycles, lw 5, sw 4, beq/j 3; each memory wait cycle adds 1.
// Backpressure: FETCH and MEM hold the request steady until mem_ack is sampled; no other state stalls.
//
// Ports:
//   clk, rst          - single clock; synchronous active-high reset
//   mem_req/mem_we    - memory request and direction (1 = write)
//   mem_addr          - word-aligned byte address (PC in FETCH, ALUOut in MEM)
//   mem_wdata         - store data (B register during sw), zero otherwise
//   mem_rdata/mem_ack - read data and completion strobe for the current request
//   halted            - core has reached the absorbing HALT state
//   pc_dbg            - current program counter
//
// Optional feature: define MIPS_MC_JAL_EN to implement jal (op 0x03) and jr (funct 0x08).
// Without it both encodings are treated as illegal and halt the core.
module mips_multicycle #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                NREGS    = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_dbg
);

  localparam int RI_W = $clog2(NREGS);
  // Link register index after aliasing into the implemented register file.
  localparam logic [RI_W-1:0] RA_I = RI_W'(31);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  typedef enum logic [3:0] {C_BAD, C_RTYPE, C_ADDI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_JR} cls_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_ir;
  logic [31:0]       r_a;
  logic [31:0]       r_b;
  logic [31:0]       r_simm;
  logic [31:0]       r_aluout;
  logic [31:0]       r_mdr;
  logic [31:0]       r_regs [NREGS];

  cls_t              w_cls;
  logic [31:0]       w_alu;
  logic [5:0]        w_op;
  logic [5:0]        w_funct;
  logic [RI_W-1:0]   w_rs_i;
  logic [RI_W-1:0]   w_rt_i;
  logic [RI_W-1:0]   w_rd_i;
  logic [RI_W-1:0]   w_wb_i;
  logic [31:0]       w_wb_val;
  logic [31:0]       w_rs_val;
  logic [31:0]       w_rt_val;
  logic [ADDR_W-1:0] w_jt;
  logic [ADDR_W-1:0] w_br;
  logic              w_unused;

  assign w_op    = r_ir[31:26];
  assign w_funct = r_ir[5:0];
  // Register specifiers alias modulo NREGS by keeping only the low bits.
  assign w_rs_i  = r_ir[21 +: RI_W];
  assign w_rt_i  = r_ir[16 +: RI_W];
  assign w_rd_i  = r_ir[11 +: RI_W];

  assign w_rs_val = (w_rs_i == '0) ? '0 : r_regs[w_rs_i];
  assign w_rt_val = (w_rt_i == '0) ? '0 : r_regs[w_rt_i];

  assign w_jt = ADDR_W'({4'b0000, r_ir[25:0], 2'b00});
  assign w_br = r_pc + ADDR_W'(r_simm << 2);

  assign w_wb_i   = (w_cls == C_RTYPE) ? w_rd_i : w_rt_i;
  assign w_wb_val = (w_cls == C_LW) ? r_mdr : r_aluout;

  // Instruction classification and ALU; lw/sw reuse the adder for the effective address.
  always_comb begin
    w_cls = C_BAD;
    w_alu = '0;
    case (w_op)
      6'h00: begin
        case (w_funct)
          6'h20: begin w_cls = C_RTYPE; w_alu = r_a + r_b; end
          6'h22: begin w_cls = C_RTYPE; w_alu = r_a - r_b; end
          6'h24: begin w_cls = C_RTYPE; w_alu = r_a & r_b; end
          6'h25: begin w_cls = C_RTYPE; w_alu = r_a | r_b; end
          6'h2A: begin w_cls = C_RTYPE; w_alu = {31'd0, ($signed(r_a) < $signed(r_b))}; end
`ifdef MIPS_MC_JAL_EN
          6'h08: w_cls = C_JR;
`endif
          default: w_cls = C_BAD;
        endcase
      end
      6'h08: begin w_cls = C_ADDI; w_alu = r_a + r_simm; end
      6'h23: begin w_cls = C_LW;   w_alu = r_a + r_simm; end
      6'h2B: begin w_cls = C_SW;   w_alu = r_a + r_simm; end
      6'h04: w_cls = C_BEQ;
      6'h02: w_cls = C_J;
`ifdef MIPS_MC_JAL_EN
      6'h03: w_cls = C_JAL;
`endif
      default: w_cls = C_BAD;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH:  if (mem_ack) w_next = DECODE;
      DECODE: w_next = EXEC;
      EXEC: begin
        case (w_cls)
          C_RTYPE, C_ADDI: w_next = WB;
          C_LW, C_SW:      w_next = MEM;
          C_BAD:           w_next = HALT;
          default:         w_next = FETCH;
        endcase
      end
      MEM:     if (mem_ack) w_next = (w_cls == C_SW) ? FETCH : WB;
      WB:      w_next = FETCH;
      HALT:    w_next = HALT;
      default: w_next = HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= FETCH;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_simm   <= '0;
      r_aluout <= '0;
      r_mdr    <= '0;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        FETCH: begin
          if (mem_ack) begin
            r_ir <= mem_rdata;
            r_pc <= r_pc + ADDR_W'(4);
          end
        end
        DECODE: begin
          r_a    <= w_rs_val;
          r_b    <= w_rt_val;
          r_simm <= {{16{r_ir[15]}}, r_ir[15:0]};
        end
        EXEC: begin
          case (w_cls)
            C_RTYPE, C_ADDI, C_LW, C_SW: r_aluout <= w_alu;
            C_BEQ: if (r_a == r_b) r_pc <= w_br;
            C_J:   r_pc <= w_jt;
            C_JAL: begin
              // PC already points past the jal, which is the return address.
              r_regs[RA_I] <= 32'(r_pc);
              r_pc         <= w_jt;
            end
            C_JR:    r_pc <= r_a[ADDR_W-1:0];
            default: ;
          endcase
        end
        MEM:     if (mem_ack && (w_cls == C_LW)) r_mdr <= mem_rdata;
        WB:      if (w_wb_i != '0) r_regs[w_wb_i] <= w_wb_val;
        default: ;
      endcase
    end
  end

  // Request outputs follow the state; rst masks them so no request is seen while reset is held.
  assign mem_req   = !rst && ((r_state == FETCH) || (r_state == MEM));
  assign mem_we    = !rst && (r_state == MEM) && (w_cls == C_SW);
  assign mem_addr  = (r_state == MEM) ? {r_aluout[ADDR_W-1:2], 2'b00} : r_pc;
  assign mem_wdata = mem_we ? r_b : '0;
  assign halted    = (r_state == HALT);
  assign pc_dbg    = r_pc;

  // Shamt and the aliased-away specifier/address bits are intentionally ignored.
  assign w_unused = ^{r_ir, r_aluout};

endmodule

// File: tb/tb_mips_multicycle.sv
module tb_mips_multicycle;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        halted;
  logic [15:0] pc_dbg;

  mips_multicycle #(.ADDR_W(16), .RESET_PC(16'h0100), .NREGS(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .halted    (halted),
    .pc_dbg    (pc_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          cyc;
  } txn_t;

  localparam logic [31:0] OP_HALT = 32'hFC000000;

  txn_t        sb[$];
  txn_t        mon_e;
  logic [31:0] mem [256];
  int          checks = 0;
  int          failures = 0;
  int          ws = 0;
  int          cyc = 0;
  int          wcnt = 0;
  logic        force_ack = 1'b0;
  logic        prev_open = 1'b0;
  logic        prev_we = 1'b0;
  logic [15:0] prev_addr = '0;
  logic [31:0] prev_wdata = '0;

  task automatic expect_txn(input logic we, input logic [15:0] addr, input logic [31:0] wdata, input int c);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wdata; t.cyc = c;
    sb.push_back(t);
  endtask

  task automatic load(input logic [15:0] a, input logic [31:0] w);
    mem[a[9:2]] = w;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic rst_on();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_pc", {16'd0, pc_dbg}, 32'h0100);
  endtask

  task automatic wait_drain(input int maxc);
    int n = 0;
    while (sb.size() != 0 && n < maxc) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d transactions still outstanding, want 0", sb.size());
      sb.delete();
    end
  endtask

  // Memory responder and scoreboard monitor, evaluated mid-cycle when DUT outputs are settled.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) cyc = 0;
      else     cyc++;
      if (mem_req && prev_open) begin
        checks++;
        if (mem_addr !== prev_addr || mem_we !== prev_we || mem_wdata !== prev_wdata) begin
          failures++;
          $display("FAIL hold: got we=%0b addr=%h wdata=%h, want we=%0b addr=%h wdata=%h",
                   mem_we, mem_addr, mem_wdata, prev_we, prev_addr, prev_wdata);
        end
      end
      if (mem_req) begin
        if (wcnt >= ws) begin
          mem_ack   = 1'b1;
          mem_rdata = mem[mem_addr[9:2]];
          wcnt      = 0;
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL txn: unexpected we=%0b addr=%h wdata=%h cyc=%0d", mem_we, mem_addr, mem_wdata, cyc);
          end else begin
            mon_e = sb.pop_front();
            if (mem_we !== mon_e.we || mem_addr !== mon_e.addr || cyc != mon_e.cyc ||
                (mon_e.we && mem_wdata !== mon_e.wdata)) begin
              failures++;
              $display("FAIL txn: got we=%0b addr=%h wdata=%h cyc=%0d, want we=%0b addr=%h wdata=%h cyc=%0d",
                       mem_we, mem_addr, mem_wdata, cyc, mon_e.we, mon_e.addr, mon_e.wdata, mon_e.cyc);
            end
          end
        end else begin
          mem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        mem_ack = force_ack;
        wcnt    = 0;
      end
      prev_open  = mem_req && !mem_ack;
      prev_we    = mem_we;
      prev_addr  = mem_addr;
      prev_wdata = mem_wdata;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = OP_HALT;

    // Arithmetic then store, zero-wait, ending in an illegal opcode.
    rst_on();
    ws = 0;
    load(16'h0100, 32'h20010005);  // addi $1,$0,5
    load(16'h0104, 32'h2002FFFD);  // addi $2,$0,-3
    load(16'h0108, 32'h00221820);  // add  $3,$1,$2
    load(16'h010C, 32'hAC030040);  // sw   $3,0x40($0)
    load(16'h0110, OP_HALT);
    expect_txn(1'b0, 16'h0100, 32'd0, 1);
    expect_txn(1'b0, 16'h0104, 32'd0, 5);
    expect_txn(1'b0, 16'h0108, 32'd0, 9);
    expect_txn(1'b0, 16'h010C, 32'd0, 13);
    expect_txn(1'b1, 16'h0040, 32'h00000002, 16);
    expect_txn(1'b0, 16'h0110, 32'd0, 17);
    rst = 1'b0;
    wait_drain(200);
    chk("t1_not_halted_in_decode", {31'd0, halted}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("t1_halted", {31'd0, halted}, 32'd1);
    chk("t1_halt_pc", {16'd0, pc_dbg}, 32'h0114);
    repeat (4) @(posedge clk);
    #1;
    chk("t1_halt_no_req", {31'd0, mem_req}, 32'd0);
    chk("t1_still_halted", {31'd0, halted}, 32'd1);

    // lw with three wait states on every access; result observed via a store.
    rst_on();
    ws = 3;
    load(16'h0040, 32'h00000002);
    load(16'h0100, 32'h8C040040);  // lw $4,0x40($0)
    load(16'h0104, 32'hAC040044);  // sw $4,0x44($0)
    load(16'h0108, OP_HALT);
    expect_txn(1'b0, 16'h0100, 32'd0, 4);
    expect_txn(1'b0, 16'h0040, 32'd0, 10);
    expect_txn(1'b0, 16'h0104, 32'd0, 15);
    expect_txn(1'b1, 16'h0044, 32'h00000002, 21);
    expect_txn(1'b0, 16'h0108, 32'd0, 25);
    rst = 1'b0;
    wait_drain(300);
    repeat (2) @(posedge clk);
    #1;
    chk("t2_halted", {31'd0, halted}, 32'd1);

    // Remaining ALU ops, register 0, jump and a beq self-loop.
    rst_on();
    ws = 0;
    load(16'h0100, 32'h20010005);  // addi $1,$0,5
    load(16'h0104, 32'h2002FFFD);  // addi $2,$0,-3
    load(16'h0108, 32'h00222822);  // sub  $5,$1,$2  -> 8
    load(16'h010C, 32'h00223024);  // and  $6,$1,$2  -> 5
    load(16'h0110, 32'h00223825);  // or   $7,$1,$2  -> FFFFFFFD
    load(16'h0114, 32'h0041402A);  // slt  $8,$2,$1  -> 1
    load(16'h0118, 32'h0022482A);  // slt  $9,$1,$2  -> 0
    load(16'h011C, 32'h00210020);  // add  $0,$1,$1  (discarded)
    load(16'h0120, 32'hAC050080);  // sw $5,0x80($0)
    load(16'h0124, 32'hAC060084);  // sw $6,0x84($0)
    load(16'h0128, 32'hAC070088);  // sw $7,0x88($0)
    load(16'h012C, 32'hAC08008C);  // sw $8,0x8C($0)
    load(16'h0130, 32'hAC090094);  // sw $9,0x94($0)
    load(16'h0134, 32'hAC000090);  // sw $0,0x90($0)
    load(16'h0138, 32'h08000004);  // j 0x00004 -> 0x0010
    load(16'h0010, 32'h1000FFFF);  // beq $0,$0,-1
    for (int k = 0; k < 8; k++) expect_txn(1'b0, 16'(16'h0100 + 4 * k), 32'd0, 1 + 4 * k);
    expect_txn(1'b0, 16'h0120, 32'd0, 33); expect_txn(1'b1, 16'h0080, 32'h00000008, 36);
    expect_txn(1'b0, 16'h0124, 32'd0, 37); expect_txn(1'b1, 16'h0084, 32'h00000005, 40);
    expect_txn(1'b0, 16'h0128, 32'd0, 41); expect_txn(1'b1, 16'h0088, 32'hFFFFFFFD, 44);
    expect_txn(1'b0, 16'h012C, 32'd0, 45); expect_txn(1'b1, 16'h008C, 32'h00000001, 48);
    expect_txn(1'b0, 16'h0130, 32'd0, 49); expect_txn(1'b1, 16'h0094, 32'h00000000, 52);
    expect_txn(1'b0, 16'h0134, 32'd0, 53); expect_txn(1'b1, 16'h0090, 32'h00000000, 56);
    expect_txn(1'b0, 16'h0138, 32'd0, 57);
    expect_txn(1'b0, 16'h0010, 32'd0, 60);
    expect_txn(1'b0, 16'h0010, 32'd0, 63);
    expect_txn(1'b0, 16'h0010, 32'd0, 66);
    rst = 1'b0;
    wait_drain(300);

    // Jumps with one wait state, including j 0x00040 -> 0x0100.
    rst_on();
    ws = 1;
    load(16'h0100, 32'h08000050);  // j 0x00050 -> 0x0140
    load(16'h0140, 32'h08000040);  // j 0x00040 -> 0x0100
    expect_txn(1'b0, 16'h0100, 32'd0, 2);
    expect_txn(1'b0, 16'h0140, 32'd0, 6);
    expect_txn(1'b0, 16'h0100, 32'd0, 10);
    rst = 1'b0;
    wait_drain(200);

    // jal and jr are illegal in the default build.
    rst_on();
    ws = 0;
    load(16'h0100, 32'h0C000000);  // jal 0
    expect_txn(1'b0, 16'h0100, 32'd0, 1);
    rst = 1'b0;
    wait_drain(100);
    chk("t5a_not_halted_early", {31'd0, halted}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("t5a_halted", {31'd0, halted}, 32'd1);
    chk("t5a_pc", {16'd0, pc_dbg}, 32'h0104);

    rst_on();
    load(16'h0100, 32'h03E00008);  // jr $31
    expect_txn(1'b0, 16'h0100, 32'd0, 1);
    rst = 1'b0;
    wait_drain(100);
    repeat (2) @(posedge clk);
    #1;
    chk("t5b_halted", {31'd0, halted}, 32'd1);
    chk("t5b_pc", {16'd0, pc_dbg}, 32'h0104);

    // Reset in the middle of a wait-stated sw, with a late ack while reset is held.
    rst_on();
    ws = 3;
    load(16'h0040, 32'h00000055);
    load(16'h0100, 32'h20010007);  // addi $1,$0,7
    load(16'h0104, 32'hAC010040);  // sw $1,0x40($0)
    load(16'h0108, OP_HALT);
    expect_txn(1'b0, 16'h0100, 32'd0, 4);
    expect_txn(1'b0, 16'h0104, 32'd0, 11);
    rst = 1'b0;
    wait_drain(200);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_sw_req", {31'd0, mem_req}, 32'd1);
    chk("t6_sw_we", {31'd0, mem_we}, 32'd1);
    chk("t6_sw_addr", {16'd0, mem_addr}, 32'h0040);
    chk("t6_sw_wdata", mem_wdata, 32'h00000007);
    rst = 1'b1;
    force_ack = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_req_dropped", {31'd0, mem_req}, 32'd0);
    chk("t6_pc_reset", {16'd0, pc_dbg}, 32'h0100);
    @(posedge clk);
    #1;
    ws = 0;
    force_ack = 1'b0;
    load(16'h0100, 32'hAC010048);  // sw $1,0x48($0): $1 must read back as 0
    load(16'h0104, OP_HALT);
    expect_txn(1'b0, 16'h0100, 32'd0, 1);
    expect_txn(1'b1, 16'h0048, 32'h00000000, 4);
    expect_txn(1'b0, 16'h0104, 32'd0, 5);
    rst = 1'b0;
    wait_drain(100);
    repeat (2) @(posedge clk);
    #1;
    chk("t6_halted", {31'd0, halted}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_multicycle.md
MIPS_MULTICYCLE -- requirements
Module: mips_multicycle

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: byte-address width of the memory port; PC is ADDR_W bits.
REQ-002 SHALL have parameter RESET_PC, default 0: PC value loaded on reset.
REQ-003 SHALL have parameter NREGS, default 32, legal values 8/16/32: number of implemented registers; higher-numbered register specifiers alias modulo NREGS.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port mem_req, output, 1 bit: memory transaction request.
REQ-007 SHALL have port mem_we, output, 1 bit: 1 = write, 0 = read.
REQ-008 SHALL have port mem_addr, output, ADDR_W bits: byte address, word-aligned (low 2 bits zero).
REQ-009 SHALL have port mem_wdata, output, 32 bits: store data.
REQ-010 SHALL have port mem_rdata, input, 32 bits: read data, valid in the ack cycle.
REQ-011 SHALL have port mem_ack, input, 1 bit: completes the current request.
REQ-012 SHALL have port halted, output, 1 bit: core is in HALT.
REQ-013 SHALL have port pc_dbg, output, ADDR_W bits: current PC.

Function
REQ-014 SHALL use the FSM states FETCH, DECODE, EXEC, MEM, WB, HALT, with one unified memory port for instructions and data.
REQ-015 FETCH SHALL drive mem_req=1, mem_we=0, mem_addr=PC and hold them; on mem_ack, IR<=mem_rdata, PC<=PC+4 (mod 2^ADDR_W), next state DECODE.
REQ-016 DECODE SHALL take 1 cycle: latch rs and rt register values into A and B, and latch the sign-extended imm16; next state EXEC.
REQ-017 SHALL support: R-type (op 0) add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed); addi 0x08; lw 0x23; sw 0x2B; beq 0x04; j 0x02.
REQ-018 EXEC SHALL behave per instruction class:
- R-type/addi: ALUOut<=result, go to WB.
- lw/sw: ALUOut<=A+simm, go to MEM.
- beq: if A==B then PC<=PC+(simm<<2), go to FETCH.
- j: PC<={imm26,2'b00}[ADDR_W-1:0], go to FETCH.
REQ-019 An R-type with an unlisted funct, or an unlisted opcode, SHALL move to HALT from EXEC with no state side effects.
REQ-020 MEM SHALL drive mem_addr=ALUOut[ADDR_W-1:0]&~3 and mem_we=(sw), plus mem_wdata=B for sw; on mem_ack, sw goes to FETCH and lw latches MDR<=mem_rdata, then goes to WB.
REQ-021 WB SHALL write ALUOut (R-type to rd, addi to rt) or MDR (lw to rt); writes to register 0 SHALL be discarded and reads of register 0 SHALL return 0; next state FETCH.
REQ-022 Handshake: mem_req, mem_we, mem_addr and mem_wdata SHALL be stable from assertion until the cycle mem_ack=1 is sampled; mem_ack=1 in the first request cycle (zero-wait) SHALL complete it; mem_ack while mem_req=0 SHALL be ignored.
REQ-023 mem_req SHALL be 0 in DECODE, EXEC, WB and HALT.
REQ-024 Arithmetic SHALL be 32-bit two's-complement with wrap and no overflow trap; a branch or jump target SHALL truncate to ADDR_W bits.
REQ-025 Instruction latency SHALL be, with zero-wait memory: R/addi 4 cycles, lw 5, sw 4, beq/j 3; each wait cycle adds 1.
REQ-026 HALT SHALL be absorbing until rst; halted=1 only in HALT.

Reset
REQ-027 On rst=1 at a clock edge: PC<=RESET_PC, state<=FETCH, mem_req<=0, mem_we<=0, mem_wdata<=0, halted<=0, and all registers <=0; this SHALL take priority over any in-flight transaction, whose late mem_ack SHALL be ignored.
REQ-028 FETCH SHALL assert mem_req on the first cycle after rst deasserts.

Configuration
REQ-029 With macro MIPS_MC_JAL_EN defined: jal (0x03) SHALL write PC (already +4) to register 31 in EXEC, then PC<=target; jr (funct 0x08) SHALL set PC<=A[ADDR_W-1:0]; both go to FETCH in 3 cycles.
REQ-030 Without MIPS_MC_JAL_EN: jal and jr SHALL be unlisted and go to HALT.

Verification
REQ-031 Reset with RESET_PC=0x0100, memory zero-wait -> first request mem_addr=0x0100, mem_we=0 on the cycle after rst falls.
REQ-032 Program addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; sw $3,0x40($0) -> write request addr 0x0040, wdata 0x00000002, all completed in 16 cycles.
REQ-033 Memory with 3 wait states on every access running lw $4,0x40($0) -> mem_addr held at 0x0040 for 4 cycles, $4=0x00000002, instruction takes 11 cycles.
REQ-034 beq $0,$0,-1 at PC 0x0010 -> next fetch at 0x0010 (loop); j 0x00040 -> next fetch 0x0100.
REQ-035 Opcode 0x3F -> halted=1 after EXEC, mem_req stays 0; rst -> halted=0 and fetch restarts at RESET_PC.
REQ-036 rst asserted during a wait-stated sw -> mem_req=0 next cycle, no register change, late mem_ack ignored.
